load_store_wb: RTL
==================

// Module: load_store_wb
// PURPOSE
//  Memory/writeback stage of the RV32 core, directly upstream of the register file.
//  - Accepts one op at a time from execute and runs RV32I loads/stores on a valid/ready data-memory port.
//  - Aligns and sign-extends load data.
//  - Drives the register-file write port: reg_write/wb_rd/wb_data map to regWrite/rd/wd.
//  - ALU results pass straight through to writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in WAIT before bus error; 0 disables timeout
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  ex_valid        in   1   execute presents an op
//  ex_ready        out  1   stage can accept (high only in IDLE)
//  ex_is_load      in   1   op is load
//  ex_is_store     in   1   op is store (never together with ex_is_load)
//  ex_reg_write    in   1   op writes rd (ALU ops; loads imply it)
//  ex_funct3       in   3   RV32I width/sign code
//  ex_addr         in   32  ALU result: memory address or writeback value
//  ex_wdata        in   32  store data (rs2)
//  ex_rd           in   5   destination register
//  dmem_req_valid  out  1   memory request valid
//  dmem_req_ready  in   1   memory accepts request
//  dmem_req_addr   out  32  word address, {ex_addr[31:2],2'b00}
//  dmem_req_we     out  1   1 = store
//  dmem_req_be     out  4   byte enables
//  dmem_req_wdata  out  32  store data replicated into byte lanes
//  dmem_rsp_valid  in   1   read data valid (loads only)
//  dmem_rsp_rdata  in   32  read word
//  reg_write       out  1   1-cycle write strobe to register file
//  wb_rd           out  5   write register
//  wb_data         out  32  write data
//  exc_valid       out  1   1-cycle exception pulse
//  exc_cause       out  2   01 misaligned, 10 bus timeout, 11 illegal funct3
//  exc_addr        out  32  faulting ex_addr
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except ex_ready=1; counter cleared. Reset mid-op abandons the op; a later rsp is ignored.
//  - States: IDLE -> REQ (load/store accepted) -> WAIT (load handshaken) -> WB -> IDLE.
//    - Store: REQ -> IDLE on req handshake, no writeback.
//    - ALU op with ex_reg_write: IDLE -> WB directly.
//    - No-op (no flags): accepted, stays IDLE.
//  - Accept: ex_valid & ex_ready; all ex_* fields are registered on accept.
//  - Load latency: request is valid the cycle after accept and stays valid with stable fields until ready. WB is the cycle after rsp_valid.
//  - Minimum latencies: load accept->reg_write = 3 cycles (ready and rsp immediate); ALU accept->reg_write = 1 cycle.
//  - funct3: loads LB=000 LH=001 LW=010 LBU=100 LHU=101; stores SB=000 SH=001 SW=010.
//    - Any other code raises exc cause 11 the cycle after accept; no memory access.
//  - Byte enables: SB 0001<<a[1:0]; SH 0011<<a[1:0]; SW 1111.
//  - Store data: SB {4{b}}, SH {2{h}}.
//  - Loads: select the byte/halfword lane by addr[1:0]; sign- or zero-extend to 32 bits.
//  - rd==0: WB state still occupies its cycle but reg_write stays 0.
//  - rsp_valid outside WAIT is ignored.
//  - Timeout: if WAIT lasts TIMEOUT_CYCLES cycles, raise exc cause 10, go IDLE, no writeback.
//  - Exceptions: exc_* are valid only while exc_valid=1; the stage returns to IDLE in the same cycle.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - halfword with a[0]!=0 or word with a[1:0]!=0 raises exc cause 01 the cycle after accept;
//    - no request is issued and no writeback occurs.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - low address bits are forced aligned (LH/LHU/SH use a[1], LW/SW ignore a[1:0]);
//    - the access proceeds and no cause 01 is ever raised.
// TESTING
//  - LW x5 @0x100, ready=1, rsp next cycle data 0xDEADBEEF -> reg_write, wb_rd=5, wb_data=0xDEADBEEF, 3 cycles after accept.
//  - LB @0x103, rdata 0x80FFFFFF -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LHU @0x102 -> 0x000080FF.
//  - SH @0x106, wdata 0x1234ABCD, ready low 3 cycles -> req held stable, addr 0x104, be 1100, wdata 0xABCDABCD; no reg_write.
//  - ALU op rd=0, value 7 -> no reg_write; next ALU rd=3, value 7 -> reg_write next cycle with wb_data=7.
//  - Load, rsp never arrives, TIMEOUT_CYCLES=4 -> exc_valid cause 10 after 4 WAIT cycles; ex_ready returns; late rsp ignored.
//  - LW @0x101 with macro -> cause 01, exc_addr 0x101, no dmem_req_valid; without macro -> access at 0x100.
//  - Assert rst_n low while in WAIT -> outputs 0 immediately, ex_ready=1 after release.

Source files
------------

// File: rtl/load_store_wb_if.sv
// load_store_wb_if: execute, data-memory and register-file signals of the load/store/writeback stage.
// The master modport is the stage itself; the slave modport is the surrounding core/memory.
interface load_store_wb_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic        ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    modport master (
        input  ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output ex_ready,
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata,
        output reg_write, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );

    modport slave (
        output ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  ex_ready,
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata,
        input  reg_write, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );
endinterface

// File: rtl/load_store_wb.sv
// load_store_wb: RV32 memory/writeback stage (loads, stores, ALU pass-through to the register file).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise low address bits are forced aligned.
module load_store_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    load_store_wb_if.master bus
);
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_WB = 2'd3} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_valid_q, req_valid_d;
    logic          req_we_q, req_we_d;
    logic [3:0]    req_be_q, req_be_d;
    logic [31:0]   req_wdata_q, req_wdata_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          exc_valid_q, exc_valid_d;
    logic [1:0]    exc_cause_q, exc_cause_d;
    logic [31:0]   exc_addr_q, exc_addr_d;
    logic          misalign_s;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_offset = a;
            2'b01:   lane_offset = {a[1], 1'b0};
            default: lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   byte_enables = 4'b0001 << off;
            2'b01:   byte_enables = 4'b0011 << off;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // funct3[2] set means zero-extend (LBU/LHU)
    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   load_align = f3[2] ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   load_align = f3[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_align = w;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_addr[0]) ||
                        ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        reg_write_d = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ex_valid && (bus.ex_is_load || bus.ex_is_store)) begin
                    if (!f3_legal(bus.ex_is_load, bus.ex_funct3) || misalign_s) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = misalign_s && f3_legal(bus.ex_is_load, bus.ex_funct3) ? 2'b01 : 2'b11;
                        exc_addr_d  = bus.ex_addr;
                    end else begin
                        state_d     = ST_REQ;
                        f3_d        = bus.ex_funct3;
                        off_d       = lane_offset(bus.ex_funct3, bus.ex_addr[1:0]);
                        rd_d        = bus.ex_rd;
                        addr_d      = bus.ex_addr;
                        req_valid_d = 1'b1;
                        req_we_d    = bus.ex_is_store;
                        req_be_d    = byte_enables(bus.ex_funct3,
                                                   lane_offset(bus.ex_funct3, bus.ex_addr[1:0]));
                        req_wdata_d = store_lanes(bus.ex_funct3, bus.ex_wdata);
                    end
                end else if (bus.ex_valid && bus.ex_reg_write) begin
                    state_d     = ST_WB;
                    reg_write_d = (bus.ex_rd != 5'd0);
                    wb_rd_d     = bus.ex_rd;
                    wb_data_d   = bus.ex_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_we_q ? ST_IDLE : ST_WAIT;
                    cnt_d       = '0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_rsp_valid) begin
                    state_d     = ST_WB;
                    reg_write_d = (rd_q != 5'd0);
                    wb_rd_d     = rd_q;
                    wb_data_d   = load_align(f3_q, off_q, bus.dmem_rsp_rdata);
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = ST_IDLE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = 2'b10;
                    exc_addr_d  = addr_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            addr_q      <= 32'd0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_be_q    <= 4'd0;
            req_wdata_q <= 32'd0;
            reg_write_q <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            reg_write_q <= reg_write_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign bus.ex_ready       = (state_q == ST_IDLE);
    assign bus.dmem_req_valid = req_valid_q;
    assign bus.dmem_req_addr  = {addr_q[31:2], 2'b00};
    assign bus.dmem_req_we    = req_we_q;
    assign bus.dmem_req_be    = req_be_q;
    assign bus.dmem_req_wdata = req_wdata_q;
    assign bus.reg_write      = reg_write_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.exc_valid      = exc_valid_q;
    assign bus.exc_cause      = exc_cause_q;
    assign bus.exc_addr       = exc_addr_q;
endmodule
